// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen codes used by the screen multiplexer and the
// PS/2 key constants interpreted by the screen sequencer.
package vga_pkg;

    // Screen codes; the encoding is fixed because the multiplexer decodes it.
    typedef enum logic [1:0] {
        StStart   = 2'd0,
        StGame    = 2'd1,
        StPlayer1 = 2'd2,
        StPlayer2 = 2'd3
    } screen_e;

    localparam logic [1:0] SCREEN_START    = 2'd0;
    localparam logic [1:0] SCREEN_GAME     = 2'd1;
    localparam logic [1:0] SCREEN_PLAYER_1 = 2'd2;
    localparam logic [1:0] SCREEN_PLAYER_2 = 2'd3;

    // PS/2 make codes and the break prefix.
    localparam logic [7:0] KEY_START    = 8'h5A;
    localparam logic [7:0] KEY_ABORT    = 8'h76;
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    // Width of a frame counter that must hold the larger of the two frame limits.
    function automatic int unsigned hold_cnt_width(int unsigned hold_frames,
                                                   int unsigned auto_frames);
        int unsigned max_frames;
        max_frames = (hold_frames > auto_frames) ? hold_frames : auto_frames;
        if (max_frames == 0) begin
            max_frames = 1;
        end
        return $clog2(max_frames + 1);
    endfunction

endpackage

// File: rtl/screen_fsm_key_event_det.sv
// Key press detector: registers the last PS/2 scan pair and flags a new make
// code (changed value, not a break) as a one-cycle start or abort pulse.
module key_event_det
    import vga_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] keycode_i,
    output logic        start_evt_o,
    output logic        abort_evt_o
);

    logic [15:0] prev_keycode_q;
    logic        press;

    // Remember the previous scan pair so a held key is only reported once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_keycode_q <= 16'h0000;
        end else begin
            prev_keycode_q <= keycode_i;
        end
    end

    // A press is a new scan pair that is not a break code.
    always_comb begin
        press       = (keycode_i != prev_keycode_q) && (keycode_i[15:8] != BREAK_PREFIX);
        start_evt_o = press && (keycode_i[7:0] == KEY_START);
        abort_evt_o = press && (keycode_i[7:0] == KEY_ABORT);
    end

endmodule

// File: rtl/screen_fsm.sv
// Screen sequencer: START -> GAME -> PLAYER_1/PLAYER_2 -> START, driven by key
// presses and scores, committing screen changes only on a vblank rising edge.
// Optional build macro SCREEN_AUTO_RETURN_EN: win screens return to START on
// their own after AUTO_RETURN_FRAMES frames.
module screen_fsm
    import vga_pkg::*;
#(
    parameter int unsigned WIN_POINTS         = 10,
    parameter int unsigned WIN_HOLD_FRAMES    = 120,
    parameter int unsigned AUTO_RETURN_FRAMES = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic [15:0] keycode,
    input  logic [4:0]  p1_score,
    input  logic [4:0]  p2_score,
    output logic [1:0]  screen,
    output logic        game_rst,
    output logic        game_active
);

    localparam int unsigned CntW = hold_cnt_width(WIN_HOLD_FRAMES, AUTO_RETURN_FRAMES);

    localparam logic [4:0]      WinPts  = 5'(WIN_POINTS);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] HoldMax = CntW'(WIN_HOLD_FRAMES);
`ifdef SCREEN_AUTO_RETURN_EN
    localparam logic [CntW-1:0] CntSat   = CntW'(AUTO_RETURN_FRAMES);
    // Counter value at the tick that completes the auto-return period.
    localparam logic [CntW-1:0] AutoLast = CntW'(AUTO_RETURN_FRAMES - 1);
`else
    localparam logic [CntW-1:0] CntSat  = HoldMax;
`endif

    screen_e         screen_q, screen_d;
    logic            game_rst_q, game_rst_d;
    logic            game_active_q, game_active_d;
    logic            vblnk_q;
    logic            start_req_q, start_req_d;
    logic            abort_req_q, abort_req_d;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

    logic frame_tick;
    logic start_evt;
    logic abort_evt;
    logic start_now;
    logic abort_now;

    key_event_det u_key_event_det (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .keycode_i   (keycode),
        .start_evt_o (start_evt),
        .abort_evt_o (abort_evt)
    );

    // Frame tick and effective requests; a press in the tick cycle counts.
    always_comb begin
        frame_tick = vblnk & ~vblnk_q;
        start_now  = start_req_q | start_evt;
        abort_now  = abort_req_q | abort_evt;
    end

    // Next screen, hold counter and request latches, evaluated per frame tick.
    always_comb begin
        screen_d    = screen_q;
        game_rst_d  = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        start_req_d = start_now;
        abort_req_d = abort_now;

        if (frame_tick) begin
            // Requests live at most until the next tick, honoured or not.
            start_req_d = 1'b0;
            abort_req_d = 1'b0;
            unique case (screen_q)
                StStart: begin
                    if (start_now) begin
                        screen_d   = StGame;
                        game_rst_d = 1'b1;
                    end
                end
                StGame: begin
                    if (abort_now) begin
                        screen_d = StStart;
                    end else if (p1_score >= WinPts) begin
                        screen_d = StPlayer1;
                    end else if (p2_score >= WinPts) begin
                        screen_d = StPlayer2;
                    end
                end
                StPlayer1, StPlayer2: begin
                    if (hold_cnt_q != CntSat) begin
                        hold_cnt_d = hold_cnt_q + CntOne;
                    end
`ifdef SCREEN_AUTO_RETURN_EN
                    if (start_now && (hold_cnt_q >= HoldMax)) begin
                        screen_d = StStart;
                    end else if (hold_cnt_q >= AutoLast) begin
                        screen_d = StStart;
                    end
`else
                    if (start_now && (hold_cnt_q == HoldMax)) begin
                        screen_d = StStart;
                    end
`endif
                end
                default: begin
                    screen_d = StStart;
                end
            endcase
        end

        // Any screen change restarts the hold count and drops stale requests.
        if (screen_d != screen_q) begin
            hold_cnt_d  = '0;
            start_req_d = 1'b0;
            abort_req_d = 1'b0;
        end

        game_active_d = (screen_d == StGame);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            screen_q      <= StStart;
            game_rst_q    <= 1'b0;
            game_active_q <= 1'b0;
            vblnk_q       <= 1'b0;
            start_req_q   <= 1'b0;
            abort_req_q   <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            screen_q      <= screen_d;
            game_rst_q    <= game_rst_d;
            game_active_q <= game_active_d;
            vblnk_q       <= vblnk;
            start_req_q   <= start_req_d;
            abort_req_q   <= abort_req_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign screen      = screen_q;
    assign game_rst    = game_rst_q;
    assign game_active = game_active_q;

endmodule

// File: tb/tb_screen_fsm.sv
// Bench for screen_fsm: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a frame-level model.
module tb_screen_fsm;

    localparam int unsigned WinPoints = 10;
    localparam int unsigned HoldFrames = 4;
    localparam int unsigned AutoFrames = 6;
`ifdef SCREEN_AUTO_RETURN_EN
    localparam bit AutoEn = 1'b1;
`else
    localparam bit AutoEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vblnk = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic [4:0]  p1_score = 5'd0;
    logic [4:0]  p2_score = 5'd0;
    logic [1:0]  screen;
    logic        game_rst;
    logic        game_active;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    screen_fsm #(
        .WIN_POINTS         (WinPoints),
        .WIN_HOLD_FRAMES    (HoldFrames),
        .AUTO_RETURN_FRAMES (AutoFrames)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vblnk       (vblnk),
        .keycode     (keycode),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .screen      (screen),
        .game_rst    (game_rst),
        .game_active (game_active)
    );

    always #5 clk = ~clk;

    // Model state: screen as 0..3, frames spent on a win screen (unbounded),
    // pending requests and the previous inputs needed to spot edges and presses.
    typedef struct packed {
        int unsigned frames;
        logic [1:0]  scr;
        logic        grst;
        logic        active;
        logic [15:0] pk;
        logic        pv;
        logic        rs;
        logic        ra;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t c, logic vb, logic [15:0] kc,
                                          logic [4:0] s1, logic [4:0] s2);
        model_t n;
        logic   tick;
        logic   press;
        logic   want_start;
        logic   want_abort;
        n          = c;
        tick       = vb && !c.pv;
        press      = (kc != c.pk) && (kc[15:8] != 8'hF0);
        want_start = c.rs || (press && kc[7:0] == 8'h5A);
        want_abort = c.ra || (press && kc[7:0] == 8'h76);
        n.grst     = 1'b0;
        if (tick) begin
            if (c.scr == 2'd0) begin
                if (want_start) begin
                    n.scr  = 2'd1;
                    n.grst = 1'b1;
                end
            end else if (c.scr == 2'd1) begin
                if (want_abort) n.scr = 2'd0;
                else if (int'(s1) >= WinPoints) n.scr = 2'd2;
                else if (int'(s2) >= WinPoints) n.scr = 2'd3;
            end else begin
                if (want_start && c.frames >= HoldFrames) n.scr = 2'd0;
                else if (AutoEn && c.frames + 1 >= AutoFrames) n.scr = 2'd0;
                n.frames = c.frames + 1;
            end
            if (n.scr != c.scr) n.frames = 0;
            n.rs = 1'b0;
            n.ra = 1'b0;
        end else begin
            n.rs = want_start;
            n.ra = want_abort;
        end
        n.active = (n.scr == 2'd1);
        n.pk     = kc;
        n.pv     = vb;
        return n;
    endfunction

    // Model advance on each clock edge, reset asynchronously like the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, vblnk, keycode, p1_score, p2_score);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_screen", 32'(screen), 32'(m.scr));
            check("model_game_rst", 32'(game_rst), 32'(m.grst));
            check("model_game_active", 32'(game_active), 32'(m.active));
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One vblank rising edge; returns on the negedge after the tick was sampled.
    task automatic frame();
        @(negedge clk);
        vblnk = 1'b1;
        @(negedge clk);
        vblnk = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // Release then press a key so the make code is always a fresh event.
    task automatic press(input logic [7:0] code);
        @(negedge clk);
        keycode = {8'hF0, code};
        @(negedge clk);
        keycode = {8'h00, code};
    endtask

    logic [15:0] key_tab [7];

    initial begin
        key_tab[0] = 16'h005A;
        key_tab[1] = 16'h0076;
        key_tab[2] = 16'hF05A;
        key_tab[3] = 16'hF076;
        key_tab[4] = 16'h0000;
        key_tab[5] = 16'h0012;
        key_tab[6] = 16'hE05A;

        cycles(3);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_screen", 32'(screen), 32'd0);
        check("reset_game_rst", 32'(game_rst), 32'd0);
        check("reset_game_active", 32'(game_active), 32'd0);

        // Start a game from START.
        keycode = 16'h005A;
        frame();
        check("start_screen_game", 32'(screen), 32'd1);
        check("start_game_rst_pulse", 32'(game_rst), 32'd1);
        @(negedge clk);
        check("start_game_rst_drop", 32'(game_rst), 32'd0);
        check("start_game_active", 32'(game_active), 32'd1);

        // Asynchronous reset mid-frame while in GAME.
        #1 rst_n = 1'b0;
        keycode = 16'h0000;
        #1;
        check("async_reset_screen", 32'(screen), 32'd0);
        check("async_reset_game_rst", 32'(game_rst), 32'd0);
        cycles(3);
        rst_n = 1'b1;

        // Held key then break, no tick: no change; next tick starts once.
        @(negedge clk);
        keycode = 16'h005A;
        cycles(50);
        keycode = 16'hF05A;
        cycles(3);
        check("held_key_no_tick", 32'(screen), 32'd0);
        frame();
        check("held_key_next_tick", 32'(screen), 32'd1);
        frame();
        check("held_key_single", 32'(screen), 32'd1);

        // Abort back to START.
        press(8'h76);
        frame();
        check("abort_to_start", 32'(screen), 32'd0);

        // Simultaneous win resolves to PLAYER_1.
        p1_score = 5'd10;
        p2_score = 5'd10;
        press(8'h5A);
        frame();
        frame();
        check("tie_player1", 32'(screen), 32'd2);

        // Key accepted once the hold period has elapsed.
        frames(4);
        press(8'h5A);
        frame();
        check("p1_hold_return", 32'(screen), 32'd0);

        // No winner keeps GAME; p2 alone wins.
        p1_score = 5'd9;
        p2_score = 5'd9;
        press(8'h5A);
        frame();
        frame();
        check("no_winner_game", 32'(screen), 32'd1);
        p2_score = 5'd12;
        frame();
        check("p2_wins", 32'(screen), 32'd3);

        // Early press discarded, later press honoured.
        frames(2);
        press(8'h5A);
        frame();
        check("p2_early_press", 32'(screen), 32'd3);
        frame();
        press(8'h5A);
        frame();
        check("p2_late_press", 32'(screen), 32'd0);

        // Win screen with no keys: auto return only when the feature is built.
        p1_score = 5'd10;
        p2_score = 5'd0;
        press(8'h5A);
        frame();
        frame();
        check("auto_enter_p1", 32'(screen), 32'd2);
        frames(5);
        check("auto_before_limit", 32'(screen), 32'd2);
        frame();
        check("auto_at_limit", 32'(screen), AutoEn ? 32'd0 : 32'd2);
        frames(14);
        check("auto_after_20", 32'(screen), AutoEn ? 32'd0 : 32'd2);

        // Randomized run checked by the every-cycle comparison.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            vblnk = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) keycode = key_tab[$urandom_range(0, 6)];
            if ($urandom_range(0, 15) == 0) begin
                p1_score = 5'($urandom_range(0, 12));
                p2_score = 5'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 799) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
